// File: rtl/vec_dot_pipe.sv
// vec_dot_pipe: streaming, pipelined dot-product unit.
// Each accepted beat is captured and its lane products are registered. The products
// are then reduced by a registered binary adder tree, one level per stage. Finally the
// per-beat sums are accumulated per group, and one result is emitted on the group's
// last beat.
//
// Handshake: a beat transfers on i_valid && o_ready, and a result transfers on
// o_valid && i_ready. The whole pipe advances together on en. en is low only while a
// result is waiting on a stalled consumer, so results never change while stalled.
module vec_dot_pipe #(
    parameter int BIT_WIDTH = 4,
    parameter int VEC_SIZE  = 64,
    parameter int NUM_LEVEL = $clog2(VEC_SIZE),
    parameter int ACC_EXTRA = 8,
    parameter int ACC_WIDTH = 2*BIT_WIDTH + NUM_LEVEL + ACC_EXTRA
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [VEC_SIZE*BIT_WIDTH-1:0] i_a,
    input  logic [VEC_SIZE*BIT_WIDTH-1:0] i_b,
    input  logic                          i_signed,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ACC_WIDTH-1:0]          o_result,
    output logic                          o_ovf
);
    // Tree width: exact for VEC_SIZE products of 2*BIT_WIDTH bits in either mode.
    localparam int TW    = 2*BIT_WIDTH + NUM_LEVEL + 1;
    // Exact accumulate width.
    localparam int SW    = ACC_WIDTH + 2;
    // Control stages: input capture, product stage, NUM_LEVEL tree stages.
    localparam int NS    = NUM_LEVEL + 2;
    // Heap-ordered tree: node k has children 2k+1 and 2k+2, leaves start at VEC_SIZE-1.
    localparam int NODES = 2*VEC_SIZE - 1;

    logic en;
    logic run;
    logic accept;
    logic grp_open;
    logic grp_mode;
    logic beat_mode;

    assign en        = !(o_valid && !i_ready);
    assign o_ready   = en && run;
    assign accept    = i_valid && o_ready;
    // The group's mode is taken from its first beat. Later beats inherit it.
    assign beat_mode = grp_open ? grp_mode : i_signed;

    logic [NS-1:0] st_valid;
    logic [NS-1:0] st_last;
    logic [NS-1:0] st_mode;

    // Ready is withheld until the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) run <= 1'b0;
        else       run <= 1'b1;
    end

    // Group tracking: open on a non-last beat, close on a last beat, latch mode at open.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grp_open <= 1'b0;
            grp_mode <= 1'b0;
        end else if (accept) begin
            if (!grp_open) grp_mode <= i_signed;
            grp_open <= !i_last;
        end
    end

    // Per-stage valid/last/mode shift register, advancing with the datapath.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_valid <= '0;
            st_last  <= '0;
            st_mode  <= '0;
        end else if (en) begin
            st_valid <= {st_valid[NS-2:0], accept};
            st_last  <= {st_last[NS-2:0], i_last};
            st_mode  <= {st_mode[NS-2:0], beat_mode};
        end
    end

    logic [VEC_SIZE*BIT_WIDTH-1:0] in_a;
    logic [VEC_SIZE*BIT_WIDTH-1:0] in_b;

    // Operand capture register. Data needs no reset because validity travels in st_valid.
    always_ff @(posedge i_clk) begin
        if (en) begin
            in_a <= i_a;
            in_b <= i_b;
        end
    end

    logic [TW-1:0] prod [VEC_SIZE];

    // Lane multipliers. Operands are extended to TW first, so the TW-bit product is
    // already the correctly extended exact product.
    for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lane
        logic [BIT_WIDTH-1:0] la;
        logic [BIT_WIDTH-1:0] lb;
        logic [TW-1:0]        ea;
        logic [TW-1:0]        eb;
        assign la = in_a[g*BIT_WIDTH +: BIT_WIDTH];
        assign lb = in_b[g*BIT_WIDTH +: BIT_WIDTH];
        assign ea = st_mode[0] ? {{(TW-BIT_WIDTH){la[BIT_WIDTH-1]}}, la}
                               : {{(TW-BIT_WIDTH){1'b0}}, la};
        assign eb = st_mode[0] ? {{(TW-BIT_WIDTH){lb[BIT_WIDTH-1]}}, lb}
                               : {{(TW-BIT_WIDTH){1'b0}}, lb};
        assign prod[g] = ea * eb;
    end

    logic [TW-1:0] node [NODES];

    // Product registers (leaves) and one registered adder level per stage up to the root.
    always_ff @(posedge i_clk) begin
        if (en) begin
            for (int k = 0; k < VEC_SIZE; k++) begin
                node[VEC_SIZE-1+k] <= prod[k];
            end
            for (int k = 0; k < VEC_SIZE-1; k++) begin
                node[k] <= node[2*k+1] + node[2*k+2];
            end
        end
    end

    logic                 fin_mode;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sticky;
    logic [SW-1:0]        acc_x;
    logic [SW-1:0]        tree_x;
    logic [SW-1:0]        sum;
    logic                 range_err;

    assign fin_mode  = st_mode[NS-1];
    assign acc_x     = fin_mode ? {{2{acc[ACC_WIDTH-1]}}, acc} : {2'b00, acc};
    assign tree_x    = fin_mode ? {{(SW-TW){node[0][TW-1]}}, node[0]}
                                : {{(SW-TW){1'b0}}, node[0]};
    assign sum       = acc_x + tree_x;
    // Signed: the top three bits must all agree. Unsigned: the two guard bits must be clear.
    assign range_err = fin_mode ? !((sum[SW-1:SW-3] == 3'b000) || (sum[SW-1:SW-3] == 3'b111))
                                : (sum[SW-1:SW-2] != 2'b00);

    // Accumulate non-last beats, and emit the result plus the overflow flag on the last beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc      <= '0;
            sticky   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_ovf    <= 1'b0;
        end else if (en) begin
            o_valid <= st_valid[NS-1] && st_last[NS-1];
            if (st_valid[NS-1]) begin
                if (st_last[NS-1]) begin
                    o_result <= sum[ACC_WIDTH-1:0];
                    o_ovf    <= sticky | range_err;
                    acc      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc    <= sum[ACC_WIDTH-1:0];
                    sticky <= sticky | range_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_dot_pipe.sv
// Bench for vec_dot_pipe.
// Two instances share one input stream: the default instance and one with zero guard bits.
// The zero-guard instance exercises wrap and overflow.
// An arithmetic reference model fills one expected queue per instance.
module tb_vec_dot_pipe;
    localparam int BW   = 4;
    localparam int VS   = 64;
    localparam int N    = BW * VS;
    localparam int AW_A = 22;
    localparam int AW_B = 14;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            i_valid, i_signed, i_last, i_ready;
    logic [N-1:0]    i_a, i_b;
    logic            o_ready_a, o_valid_a, o_ovf_a;
    logic [AW_A-1:0] o_result_a;
    logic            o_ready_b, o_valid_b, o_ovf_b;
    logic [AW_B-1:0] o_result_b;

    vec_dot_pipe #(.BIT_WIDTH(BW), .VEC_SIZE(VS), .ACC_EXTRA(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_a),
        .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_last(i_last),
        .o_valid(o_valid_a), .i_ready(i_ready), .o_result(o_result_a), .o_ovf(o_ovf_a)
    );

    vec_dot_pipe #(.BIT_WIDTH(BW), .VEC_SIZE(VS), .ACC_EXTRA(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_b),
        .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_last(i_last),
        .o_valid(o_valid_b), .i_ready(i_ready), .o_result(o_result_b), .o_ovf(o_ovf_b)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [AW_A:0] exp_a_q[$];
    logic [AW_B:0] exp_b_q[$];

    bit     mdl_open = 1'b0;
    bit     mdl_mode = 1'b0;
    longint mdl_acc[2];
    bit     mdl_sticky[2];
    int     aw_of[2];

    bit mon_on    = 1'b0;
    bit rdy_rand  = 1'b0;
    int hold_low  = 0;
    int last_wait = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint beat_sum(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg);
        longint s;
        longint va, vb;
        logic [BW-1:0] xa, xb;
        s = 0;
        for (int i = 0; i < VS; i++) begin
            xa = a[i*BW +: BW];
            xb = b[i*BW +: BW];
            va = sg ? longint'($signed(xa)) : longint'(xa);
            vb = sg ? longint'($signed(xb)) : longint'(xb);
            s += va * vb;
        end
        return s;
    endfunction

    function automatic longint wrapv(input longint v, input int aw, input bit sg);
        longint m, r;
        m = longint'(1) << aw;
        r = v % m;
        if (r < 0) r += m;
        if (sg && r >= (m >>> 1)) r -= m;
        return r;
    endfunction

    function automatic bit out_of_range(input longint v, input int aw, input bit sg);
        longint h;
        h = longint'(1) << (aw - 1);
        if (sg) return (v < -h) || (v > h - 1);
        return (v > 2*h - 1);
    endfunction

    task automatic model_accept(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg, input bit last);
        longint bs, s, w;
        logic [63:0] wv;
        bit e;
        if (!mdl_open) mdl_mode = sg;
        mdl_open = !last;
        bs = beat_sum(a, b, mdl_mode);
        for (int k = 0; k < 2; k++) begin
            s  = mdl_acc[k] + bs;
            e  = out_of_range(s, aw_of[k], mdl_mode);
            w  = wrapv(s, aw_of[k], mdl_mode);
            wv = w;
            if (last) begin
                if (k == 0) exp_a_q.push_back({mdl_sticky[k] | e, wv[AW_A-1:0]});
                else        exp_b_q.push_back({mdl_sticky[k] | e, wv[AW_B-1:0]});
                mdl_acc[k]    = 0;
                mdl_sticky[k] = 1'b0;
            end else begin
                mdl_acc[k]    = w;
                mdl_sticky[k] = mdl_sticky[k] | e;
            end
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [N-1:0] fill(input logic [BW-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < VS; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [N-1:0] r;
        for (int i = 0; i < VS; i++) r[i*BW +: BW] = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg, input bit last);
        bit done;
        done = 1'b0;
        last_wait = 0;
        while (!done) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = a; i_b = b; i_signed = sg; i_last = last;
            #1;
            if (o_ready_a) begin
                @(posedge clk);
                model_accept(a, b, sg, last);
                done = 1'b1;
                #1;
                i_valid = 1'b0;
            end else begin
                last_wait++;
                if (last_wait >= 500) begin
                    check("send_timeout", o_ready_a, 1);
                    done = 1'b1;
                    i_valid = 1'b0;
                end
            end
        end
    endtask

    // Counts rising edges until a result is presented; samples 1 time unit after each edge.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!o_valid_a && cyc < 40);
        if (!o_valid_a) check("out_timeout", o_valid_a, 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("drain_a", exp_a_q.size(), 0);
        check("drain_b", exp_b_q.size(), 0);
        repeat (12) @(negedge clk);
    endtask

    // Downstream ready: forced low windows, random, or always ready.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (hold_low > 0) begin
                i_ready = 1'b0;
                hold_low--;
            end else if (rdy_rand) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [AW_A:0]   ea;
        logic [AW_B:0]   eb;
        logic [AW_A-1:0] hold_a;
        logic [AW_B-1:0] hold_b;
        bit stall_prev;
        stall_prev = 1'b0;
        hold_a = '0;
        hold_b = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_on) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                check("hold_valid_a", o_valid_a, 1);
                check("hold_res_a", o_result_a, hold_a);
                check("hold_res_b", o_result_b, hold_b);
            end
            check("ready_a", o_ready_a, !(o_valid_a && !i_ready));
            check("ready_b", o_ready_b, !(o_valid_b && !i_ready));
            if (o_valid_a && i_ready) begin
                if (exp_a_q.size() == 0) check("unexpected_a", o_valid_a, 0);
                else begin
                    ea = exp_a_q.pop_front();
                    check("res_a", o_result_a, ea[AW_A-1:0]);
                    check("ovf_a", o_ovf_a, ea[AW_A]);
                end
            end
            if (o_valid_b && i_ready) begin
                if (exp_b_q.size() == 0) check("unexpected_b", o_valid_b, 0);
                else begin
                    eb = exp_b_q.pop_front();
                    check("res_b", o_result_b, eb[AW_B-1:0]);
                    check("ovf_b", o_ovf_b, eb[AW_B]);
                end
            end
            stall_prev = o_valid_a && !i_ready;
            hold_a = o_result_a;
            hold_b = o_result_b;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        logic [AW_A-1:0] e3;
        logic [N-1:0] va, vb;
        int len;
        int kind;
        aw_of[0] = AW_A; aw_of[1] = AW_B;
        mdl_acc[0] = 0; mdl_acc[1] = 0;
        mdl_sticky[0] = 1'b0; mdl_sticky[1] = 1'b0;
        rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_signed = 1'b0; i_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid_a", o_valid_a, 0);
        check("rst_res_a", o_result_a, 0);
        check("rst_ovf_a", o_ovf_a, 0);
        check("rst_valid_b", o_valid_b, 0);
        check("rst_res_b", o_result_b, 0);
        check("rst_ovf_b", o_ovf_b, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", o_ready_a, 1);
        @(negedge clk);
        mon_on = 1'b1;

        // T1: signed -1 * -1 over 64 lanes, single beat
        send(fill(4'hF), fill(4'hF), 1'b1, 1'b1);
        wait_out(cyc);
        check("t1_latency", cyc, 8);
        check("t1_res_a", o_result_a, 64);
        check("t1_ovf_a", o_ovf_a, 0);
        check("t1_res_b", o_result_b, 64);

        // T2: same data, unsigned
        send(fill(4'hF), fill(4'hF), 1'b0, 1'b1);
        wait_out(cyc);
        check("t2_res_a", o_result_a, 14400);
        check("t2_ovf_a", o_ovf_a, 0);
        check("t2_res_b", o_result_b, 14400);

        // T3: signed -8*7, three beats; later beats carry i_signed=0, which must be ignored
        send(fill(4'h8), fill(4'h7), 1'b1, 1'b0);
        send(fill(4'h8), fill(4'h7), 1'b0, 1'b0);
        send(fill(4'h8), fill(4'h7), 1'b0, 1'b1);
        wait_out(cyc);
        e3 = AW_A'(-10752);
        check("t3_res_a", o_result_a, e3);
        check("t3_ovf_a", o_ovf_a, 0);
        check("t3_res_b", o_result_b, 5632);
        check("t3_ovf_b", o_ovf_b, 1);

        // T5: signed -8*-8, two beats -> 8192 wraps in the 14-bit instance
        send(fill(4'h8), fill(4'h8), 1'b1, 1'b0);
        send(fill(4'h8), fill(4'h8), 1'b1, 1'b1);
        wait_out(cyc);
        check("t5_res_b", o_result_b, 14'h2000);
        check("t5_ovf_b", o_ovf_b, 1);
        check("t5_res_a", o_result_a, 8192);
        check("t5_ovf_a", o_ovf_a, 0);
        send(fill(4'hF), fill(4'hF), 1'b1, 1'b1);
        wait_out(cyc);
        check("t5_next_ovf_b", o_ovf_b, 0);
        check("t5_next_res_b", o_result_b, 64);
        drain();

        // T4: four single-beat groups, consumer stalls for 5 cycles mid-stream
        send(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        send(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            #3;
            cyc++;
        end while (!o_valid_a && cyc < 40);
        hold_low = 5;
        send(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        check("t4_stall_wait", last_wait, 5);
        send(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        drain();

        // Random groups with random backpressure and idle gaps
        rdy_rand = 1'b1;
        repeat (40) begin
            len  = $urandom_range(1, 4);
            kind = $urandom_range(0, 3);
            for (int bt = 0; bt < len; bt++) begin
                va = (kind == 0) ? fill(4'h8) : rand_vec();
                vb = (kind == 0) ? fill(4'h8) : rand_vec();
                send(va, vb, 1'($urandom_range(0, 1)), bt == len - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        rdy_rand = 1'b0;
        drain();

        // T6: reset while a group is open and beats are in flight
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        send(rand_vec(), rand_vec(), 1'b1, 1'b0);
        @(negedge clk);
        mon_on = 1'b0;
        rst = 1'b1;
        mdl_open = 1'b0;
        mdl_acc[0] = 0; mdl_acc[1] = 0;
        mdl_sticky[0] = 1'b0; mdl_sticky[1] = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
        repeat (2) @(negedge clk);
        check("t6_rst_valid_a", o_valid_a, 0);
        check("t6_rst_valid_b", o_valid_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;
        send(fill(4'hF), fill(4'hF), 1'b1, 1'b1);
        wait_out(cyc);
        check("t6_latency", cyc, 8);
        check("t6_res_a", o_result_a, 64);
        check("t6_ovf_a", o_ovf_a, 0);
        check("t6_res_b", o_result_b, 64);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
